// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Producer-side register scoreboard for the in-order pipeline. Counts the
//   register writes in flight from issue (ID->EX) to writeback retirement.
//   Tracks loads still waiting for memory data and raises the long-latency
//   load-use stall for the instruction sitting in ID. r0 is never tracked.
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   issue_*           instruction leaving ID this cycle (valid/regwrite/memread/rd)
//   mem_done, mem_rd  load data returned in MEM for register mem_rd
//   wb_regwrite/wb_rd register write retired in WB
//   flush*            instruction in EX cancelled (regwrite/memread/rd)
//   id_rs/id_rt       sources of the instruction in ID
//   id_memwrite       ID instruction is a store, so rt is store data
//   stall_n           0 = hold IF/ID and bubble ID/EX
//   busy_vec          bit i set while register i has >=1 outstanding write
//   ld_pend_vec       bit i set while register i awaits load data
//   err               sticky counter overflow/underflow flag
//
// Handshake: there is no back-pressure on the event inputs. Each of
// issue/mem/wb/flush is a one-cycle strobe, sampled on the rising edge when
// its qualifier is high. stall_n is advisory: upstream must drop issue_valid
// while stall_n=0, because this block does not gate it.

module reg_scoreboard #(
  parameter int NREG   = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_regwrite,
  input  logic              issue_memread,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              mem_done,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              flush,
  input  logic              flush_regwrite,
  input  logic              flush_memread,
  input  logic [ADDR_W-1:0] flush_rd,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_memwrite,
  output logic              stall_n,
  output logic [NREG-1:0]   busy_vec,
  output logic [NREG-1:0]   ld_pend_vec,
  output logic              err
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  ld_pend_q, ld_pend_d;
  logic [NREG-1:0]  sat_hit;
  logic             err_q, err_d;

  // Applies the net +1/-1/-1 change to one counter. The result packs the
  // saturation flag in the MSB above the clamped count.
  function automatic logic [CNT_W:0] sat_update(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec_a,
    input logic             dec_b
  );
    int net;
    net = int'(cur) + int'(inc) - int'(dec_a) - int'(dec_b);
    if (net > CNT_MAX)  sat_update = {1'b1, CNT_W'(CNT_MAX)};
    else if (net < 0)   sat_update = {1'b1, {CNT_W{1'b0}}};
    else                sat_update = {1'b0, CNT_W'(net)};
  endfunction

  // r0 is hardwired untracked.
  assign cnt_d[0]     = '0;
  assign ld_pend_d[0] = 1'b0;
  assign sat_hit[0]   = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    logic             inc, dec_wb, dec_fl, set_ld, clr_ld;
    logic [CNT_W:0]   upd;

    assign inc    = issue_valid & issue_regwrite & (issue_rd == ADDR_W'(g));
    assign dec_wb = wb_regwrite & (wb_rd == ADDR_W'(g));
    assign dec_fl = flush & flush_regwrite & (flush_rd == ADDR_W'(g));
    assign upd    = sat_update(cnt_q[g], inc, dec_wb, dec_fl);

    assign cnt_d[g]   = upd[CNT_W-1:0];
    assign sat_hit[g] = upd[CNT_W];

    // A new load is younger than the one completing or being flushed, so
    // the set takes priority over the clear.
    assign set_ld = issue_valid & issue_memread & (issue_rd == ADDR_W'(g));
    assign clr_ld = (mem_done & (mem_rd == ADDR_W'(g)))
                  | (flush & flush_memread & (flush_rd == ADDR_W'(g)));
    assign ld_pend_d[g] = set_ld | (ld_pend_q[g] & ~clr_ld);
  end

  assign err_d = err_q | (|sat_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      ld_pend_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ld_pend_q <= ld_pend_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NREG; i++) busy_vec[i] = (cnt_q[i] != '0);
  end

  assign ld_pend_vec = ld_pend_q;
  assign err         = err_q;

  // Uses registered state plus the ID sources only. There is no
  // combinational path from the event inputs. The rt check is skipped for
  // stores because their data is forwarded MEM->MEM.
  assign stall_n = ~(((id_rs != '0) & ld_pend_q[id_rs])
                   | ((id_rt != '0) & ld_pend_q[id_rt] & ~id_memwrite));

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  localparam int NREG   = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              issue_valid, issue_regwrite, issue_memread;
  logic [ADDR_W-1:0] issue_rd;
  logic              mem_done;
  logic [ADDR_W-1:0] mem_rd;
  logic              wb_regwrite;
  logic [ADDR_W-1:0] wb_rd;
  logic              flush, flush_regwrite, flush_memread;
  logic [ADDR_W-1:0] flush_rd;
  logic [ADDR_W-1:0] id_rs, id_rt;
  logic              id_memwrite;
  logic              stall_n;
  logic [NREG-1:0]   busy_vec, ld_pend_vec;
  logic              err;

  reg_scoreboard #(.NREG(NREG), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
    .issue_memread(issue_memread), .issue_rd(issue_rd),
    .mem_done(mem_done), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .flush(flush), .flush_regwrite(flush_regwrite),
    .flush_memread(flush_memread), .flush_rd(flush_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_memwrite(id_memwrite),
    .stall_n(stall_n), .busy_vec(busy_vec), .ld_pend_vec(ld_pend_vec),
    .err(err)
  );

  // ---------------- reference model ----------------
  // Abstract view: number of writes in flight per register, a pending-load
  // flag per register and a sticky error bit.
  int checks = 0;
  int errors = 0;
  int model_cnt [NREG];
  bit model_ld  [NREG];
  bit model_err;

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      model_cnt[r] = 0;
      model_ld[r]  = 0;
    end
    model_err = 0;
  endtask

  // Called right after a rising edge, with the inputs that edge sampled.
  task automatic model_clock();
    int delta [NREG];
    bit clr   [NREG];
    for (int r = 0; r < NREG; r++) begin
      delta[r] = 0;
      clr[r]   = 0;
    end
    if (issue_valid && issue_regwrite) delta[issue_rd] += 1;
    if (wb_regwrite)                   delta[wb_rd]    -= 1;
    if (flush && flush_regwrite)       delta[flush_rd] -= 1;
    if (mem_done)                      clr[mem_rd]     = 1;
    if (flush && flush_memread)        clr[flush_rd]   = 1;
    for (int r = 1; r < NREG; r++) begin
      int n;
      n = model_cnt[r] + delta[r];
      if (n > 3) begin n = 3; model_err = 1; end
      if (n < 0) begin n = 0; model_err = 1; end
      model_cnt[r] = n;
      if (clr[r]) model_ld[r] = 0;
    end
    if (issue_valid && issue_memread && issue_rd != 0) model_ld[issue_rd] = 1;
  endtask

  function automatic logic [NREG-1:0] exp_busy();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = (model_cnt[r] > 0);
    return v;
  endfunction

  function automatic logic [NREG-1:0] exp_ld();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = model_ld[r];
    return v;
  endfunction

  function automatic logic exp_stall_n();
    bit hazard;
    hazard = (id_rs != 0 && model_ld[id_rs]) ||
             (id_rt != 0 && model_ld[id_rt] && !id_memwrite);
    return !hazard;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_busy"},    32'(busy_vec),    32'(exp_busy()));
    check({tag, "_ldpend"},  32'(ld_pend_vec), 32'(exp_ld()));
    check({tag, "_stall_n"}, 32'(stall_n),     32'(exp_stall_n()));
    check({tag, "_err"},     32'(err),         32'(model_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    issue_valid = 0; issue_regwrite = 0; issue_memread = 0; issue_rd = '0;
    mem_done = 0; mem_rd = '0;
    wb_regwrite = 0; wb_rd = '0;
    flush = 0; flush_regwrite = 0; flush_memread = 0; flush_rd = '0;
    id_rs = '0; id_rt = '0; id_memwrite = 0;
  endtask

  task automatic set_issue(input logic [ADDR_W-1:0] rd, input logic is_load);
    issue_valid = 1; issue_regwrite = 1; issue_memread = is_load; issue_rd = rd;
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    check_all("reset");
    check("reset_stall_n", 32'(stall_n), 32'd1);

    // Load-use stall on r3 held while memory is outstanding.
    idle(); set_issue(4'd3, 1'b1); step("ld_issue");
    idle(); id_rs = 4'd3; #1;
    check("ld_use_stall", 32'(stall_n), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step("ld_hold");
      check("ld_hold_stall", 32'(stall_n), 32'd0);
    end
    mem_done = 1; mem_rd = 4'd3; step("ld_done");
    check("ld_release", 32'(stall_n), 32'd1);
    idle(); wb_regwrite = 1; wb_rd = 4'd3; step("ld_retire");

    // Store data on rt is exempt; rs still stalls.
    idle(); set_issue(4'd4, 1'b1); step("st_issue");
    idle(); id_rs = 4'd2; id_rt = 4'd4; id_memwrite = 1; #1;
    check("store_exempt", 32'(stall_n), 32'd1);
    id_memwrite = 0; #1;
    check("rt_nonstore_stall", 32'(stall_n), 32'd0);
    idle(); mem_done = 1; mem_rd = 4'd4; wb_regwrite = 1; wb_rd = 4'd4;
    step("st_retire");

    // r0 is ignored.
    idle(); set_issue(4'd0, 1'b1); step("r0_issue");
    idle(); #1;
    check("r0_stall", 32'(stall_n), 32'd1);
    check("r0_busy", 32'(busy_vec), 32'd0);

    // Asynchronous reset mid-run with r5 at cnt=2 and a pending load.
    idle(); set_issue(4'd5, 1'b1); step("r5_a");
    idle(); set_issue(4'd5, 1'b1); step("r5_b");
    idle(); id_rs = 4'd5; #2;
    rst = 1; #1;
    model_reset();
    check("async_rst_busy",  32'(busy_vec),    32'd0);
    check("async_rst_ld",    32'(ld_pend_vec), 32'd0);
    check("async_rst_stall", 32'(stall_n),     32'd1);
    check("async_rst_err",   32'(err),         32'd0);
    @(negedge clk); rst = 0;

    // Underflow: wb on r9 with cnt=0.
    idle(); wb_regwrite = 1; wb_rd = 4'd9; step("underflow");
    check("underflow_err", 32'(err), 32'd1);
    check("underflow_busy9", 32'(busy_vec[9]), 32'd0);
    idle(); do_reset();

    // Counter saturation on r7.
    for (int k = 0; k < 3; k++) begin
      idle(); set_issue(4'd7, 1'b0); step("cnt_fill");
    end
    check("cnt_full_err", 32'(err), 32'd0);
    idle(); set_issue(4'd7, 1'b0); step("cnt_ovf");
    check("cnt_ovf_err", 32'(err), 32'd1);
    idle(); set_issue(4'd7, 1'b0); wb_regwrite = 1; wb_rd = 4'd7; step("cnt_same");
    for (int k = 0; k < 3; k++) begin
      idle(); wb_regwrite = 1; wb_rd = 4'd7; step("cnt_drain");
      check("cnt_drain_busy7", 32'(busy_vec[7]), (k < 2) ? 32'd1 : 32'd0);
    end
    idle(); do_reset();

    // Flush plus issue on r2, load set vs completion on r6.
    idle(); set_issue(4'd2, 1'b0); step("fl_issue");
    idle(); set_issue(4'd2, 1'b0); flush = 1; flush_regwrite = 1; flush_rd = 4'd2;
    step("fl_same");
    check("fl_busy2", 32'(busy_vec[2]), 32'd1);
    idle(); set_issue(4'd6, 1'b1); mem_done = 1; mem_rd = 4'd6; step("ld_set_wins");
    check("ld_set_wins_bit", 32'(ld_pend_vec[6]), 32'd1);
    idle(); flush = 1; flush_memread = 1; flush_regwrite = 1; flush_rd = 4'd6;
    step("fl_load");
    check("fl_load_bit", 32'(ld_pend_vec[6]), 32'd0);
    check("fl_err", 32'(err), 32'd0);
    idle(); do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      issue_valid    = ($urandom_range(0, 99) < 50);
      issue_regwrite = ($urandom_range(0, 99) < 70);
      issue_memread  = ($urandom_range(0, 99) < 30);
      issue_rd       = ADDR_W'($urandom_range(0, 7));
      mem_done       = ($urandom_range(0, 99) < 30);
      mem_rd         = ADDR_W'($urandom_range(0, 7));
      wb_regwrite    = ($urandom_range(0, 99) < 35);
      wb_rd          = ADDR_W'($urandom_range(0, 7));
      flush          = ($urandom_range(0, 99) < 10);
      flush_regwrite = $urandom_range(0, 1);
      flush_memread  = $urandom_range(0, 1);
      flush_rd       = ADDR_W'($urandom_range(0, 7));
      id_rs          = ADDR_W'($urandom_range(0, 7));
      id_rt          = ADDR_W'($urandom_range(0, 7));
      id_memwrite    = $urandom_range(0, 1);
      step("rand");
      if (n % 100 == 99) begin
        idle();
        do_reset();
        check_all("rand_rst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
